game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter COUNTDOWN_SEC, default 5, pre-turn countdown length in seconds (1..9).
REQ-002 SHALL have parameter GAME_SEC, default 30, turn length in seconds (1..99).
REQ-003 SHALL have parameter NUM_PLAYERS, default 1, number of players taking turns per game (1..4).
REQ-004 SHALL have parameter SCORE_W, default 8, score width in bits.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tick_1hz  in  1  one-cycle pulse, once per second
- btn_start  in  1  one-cycle pulse; start or restart the game
- btn_pause  in  1  one-cycle pulse; pause toggle
- btn_diff  in  1  one-cycle pulse; latch difficulty
- diff_in  in  2  requested difficulty
- score  in  SCORE_W  live score from the scorer
- state_o  out  3  current state code
- clear_score  out  1  one-cycle pulse to clear the scorer
- play_en  out  1  scorer/mole enable
- difficulty  out  2  latched difficulty
- player_idx  out  2  active player
- time_bcd  out  8  remaining seconds, BCD
- disp_left  out  8  left display byte, BCD
- disp_right  out  SCORE_W  right display value
- high_score  out  SCORE_W  best turn score since reset
- new_high  out  1  one-cycle pulse on a new high score
- game_over  out  1  high while in GAME_OVER

Function
REQ-006 SHALL implement the states IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, TURN_END=4, GAME_OVER=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-007 SHALL register all outputs, aligned with the state register, with no extra cycle of lag.
REQ-008 SHALL, in IDLE, GAME_OVER, COUNTDOWN, PLAYING or PAUSED, act on btn_start by going to COUNTDOWN, setting player_idx to 0 and clearing all per-player score slots; btn_start SHALL take priority over btn_pause and tick_1hz.
REQ-009 SHALL, on entering COUNTDOWN, load time_bcd with COUNTDOWN_SEC and pulse clear_score for exactly one cycle.
REQ-010 SHALL decrement time_bcd in COUNTDOWN on each tick; a tick at value 1 SHALL enter PLAYING and load GAME_SEC into time_bcd on the same edge.
REQ-011 SHALL decrement time_bcd in BCD in PLAYING on each tick (for example 20 -> 19, 10 -> 09); a tick at value 01 SHALL set 00 and enter TURN_END.
REQ-012 SHALL assert play_en only in PLAYING.
REQ-013 SHALL handle btn_pause as follows: in PLAYING, go to PAUSED; in PAUSED, go to PLAYING; in other states, ignore it.
REQ-014 SHALL, in PAUSED, ignore tick_1hz and freeze time_bcd.
REQ-015 SHALL, when btn_pause and tick_1hz coincide in PLAYING, enter PAUSED and discard the tick.
REQ-016 SHALL, in TURN_END (one cycle), store score into slot[player_idx].
REQ-017 SHALL, in TURN_END, set high_score to score if score > high_score (strict) and pulse new_high in that cycle.
REQ-018 SHALL leave TURN_END by: if player_idx < NUM_PLAYERS-1, incrementing player_idx and going to COUNTDOWN; otherwise going to GAME_OVER.
REQ-019 SHALL, in GAME_OVER, select the winner as the highest slot score, with ties going to the lowest index.
REQ-020 SHALL drive disp_left and disp_right per state:
- IDLE: disp_left=0, disp_right=difficulty
- COUNTDOWN/PLAYING/PAUSED: disp_left=time_bcd, disp_right=score
- GAME_OVER: disp_left={4'h0, winner index}, disp_right=winner score
REQ-021 SHALL latch difficulty from diff_in on btn_diff only in IDLE or GAME_OVER, with diff_in=3 saturating to 2.
REQ-022 SHALL retain high_score across games and clear it only on reset.
REQ-023 SHALL ignore tick_1hz in IDLE, TURN_END and GAME_OVER.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE and zero every output, slot, player_idx, difficulty and high_score.
REQ-025 SHALL, on rst_n assertion mid-game, abort immediately with play_en=0 and no new_high pulse.
REQ-026 SHALL leave IDLE after reset release only on btn_start.

Verification (bench parameters: COUNTDOWN_SEC=3, GAME_SEC=12, NUM_PLAYERS=2)
REQ-027 SHALL cover: btn_start in IDLE -> one clear_score pulse, time_bcd 03,02,01 over three ticks, then PLAYING with time_bcd=12.
REQ-028 SHALL cover: 12 ticks in PLAYING -> time_bcd 11,10,09..01,00, then TURN_END, player_idx=1, COUNTDOWN with a second clear_score pulse.
REQ-029 SHALL cover: btn_pause at time_bcd=07, then 5 ticks, then btn_pause -> time_bcd stays 07 and play_en=0 while paused; the countdown resumes at 06 on the next tick.
REQ-030 SHALL cover: player 0 scores 40 and player 1 scores 40 -> GAME_OVER with disp_left=00, disp_right=40, one new_high pulse (first turn only), high_score=40.
REQ-031 SHALL cover: btn_start coinciding with btn_pause and tick_1hz in PLAYING -> COUNTDOWN, player_idx=0, time_bcd=03, not PAUSED.
REQ-032 SHALL cover: btn_diff with diff_in=3 in IDLE -> difficulty=2 and disp_right=2; btn_diff in PLAYING -> difficulty unchanged.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: whack-a-mole turn/countdown sequencer with per-player scores and high score
module game_sequencer #(
  parameter int COUNTDOWN_SEC = 5,
  parameter int GAME_SEC      = 30,
  parameter int NUM_PLAYERS   = 1,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_diff,
  input  logic [1:0]         diff_in,
  input  logic [SCORE_W-1:0] score,
  output logic [2:0]         state_o,
  output logic               clear_score,
  output logic               play_en,
  output logic [1:0]         difficulty,
  output logic [1:0]         player_idx,
  output logic [7:0]         time_bcd,
  output logic [7:0]         disp_left,
  output logic [SCORE_W-1:0] disp_right,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic               game_over
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CD   = 3'd1;
  localparam logic [2:0] S_PL   = 3'd2;
  localparam logic [2:0] S_PA   = 3'd3;
  localparam logic [2:0] S_TE   = 3'd4;
  localparam logic [2:0] S_GO   = 3'd5;
  localparam logic [7:0] CD_BCD   = 8'(COUNTDOWN_SEC);
  localparam logic [7:0] GAME_BCD = {4'(GAME_SEC / 10), 4'(GAME_SEC % 10)};
  localparam logic [1:0] LAST     = 2'(NUM_PLAYERS - 1);

  logic [2:0]         state, state_n;
  logic [7:0]         time_n, time_dec, disp_left_n;
  logic [1:0]         player_n, diff_n, win_idx;
  logic [SCORE_W-1:0] high_n, win_score, disp_right_n;
  logic [SCORE_W-1:0] slot [4];
  logic [SCORE_W-1:0] slot_n [4];
  logic               start_act, last, enter_te, beat_high;

  assign state_o   = state;
  assign start_act = btn_start && state != S_TE && state <= S_GO;
  assign last      = player_idx >= LAST;
  assign enter_te  = state_n == S_TE;
  assign beat_high = enter_te && score > high_score;
  assign time_dec  = time_bcd[3:0] == 4'd0 ? {time_bcd[7:4] - 4'd1, 4'd9}
                                           : {time_bcd[7:4], time_bcd[3:0] - 4'd1};

  // state register; codes 6-7 fall back to IDLE through the next-state logic
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;

  // next state: start wins over pause, pause wins over tick
  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE:  state_n = btn_start ? S_CD : S_IDLE;
      S_CD:    state_n = btn_start ? S_CD : (tick_1hz && time_bcd == 8'h01) ? S_PL : S_CD;
      S_PL:    state_n = btn_start ? S_CD : btn_pause ? S_PA : (tick_1hz && time_bcd == 8'h01) ? S_TE : S_PL;
      S_PA:    state_n = btn_start ? S_CD : btn_pause ? S_PL : S_PA;
      S_TE:    state_n = last ? S_GO : S_CD;
      S_GO:    state_n = btn_start ? S_CD : S_GO;
      default: state_n = S_IDLE;
    endcase
  end

  // next values of every registered output, computed from the next state so they line up with it
  always_comb begin
    time_n   = start_act ? CD_BCD
             : (state == S_CD && tick_1hz) ? (time_bcd == 8'h01 ? GAME_BCD : time_dec)
             : (state == S_PL && tick_1hz && !btn_pause) ? time_dec
             : (state == S_TE && !last) ? CD_BCD : time_bcd;
    player_n = start_act ? 2'd0 : (state == S_TE && !last) ? player_idx + 2'd1 : player_idx;
    diff_n   = (btn_diff && (state == S_IDLE || state == S_GO)) ? (diff_in == 2'd3 ? 2'd2 : diff_in) : difficulty;
    high_n   = beat_high ? score : high_score;
    for (int i = 0; i < 4; i++)
      slot_n[i] = start_act ? '0 : (enter_te && player_idx == 2'(i)) ? score : slot[i];
    win_idx   = 2'd0;
    win_score = slot[0];
    for (int i = 1; i < NUM_PLAYERS; i++)
      if (slot[i] > win_score) begin
        win_idx   = 2'(i);
        win_score = slot[i];
      end
    disp_left_n  = state_n == S_IDLE ? 8'h00 : state_n == S_GO ? {6'd0, win_idx} : time_n;
    disp_right_n = state_n == S_IDLE ? SCORE_W'(diff_n) : state_n == S_GO ? win_score : score;
  end

  // output and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      time_bcd    <= '0;
      player_idx  <= '0;
      difficulty  <= '0;
      high_score  <= '0;
      disp_left   <= '0;
      disp_right  <= '0;
      clear_score <= 1'b0;
      play_en     <= 1'b0;
      new_high    <= 1'b0;
      game_over   <= 1'b0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else begin
      time_bcd    <= time_n;
      player_idx  <= player_n;
      difficulty  <= diff_n;
      high_score  <= high_n;
      disp_left   <= disp_left_n;
      disp_right  <= disp_right_n;
      clear_score <= start_act || (state == S_TE && !last);
      play_en     <= state_n == S_PL;
      new_high    <= beat_high;
      game_over   <= state_n == S_GO;
      for (int i = 0; i < 4; i++) slot[i] <= slot_n[i];
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer (3 s countdown, 12 s turns, 2 players)
module tb_game_sequencer;
  logic       clk = 0, rst_n = 0;
  logic       tick_1hz = 0, btn_start = 0, btn_pause = 0, btn_diff = 0;
  logic [1:0] diff_in = 0;
  logic [7:0] score = 0;
  logic [2:0] state_o;
  logic       clear_score, play_en, new_high, game_over;
  logic [1:0] difficulty, player_idx;
  logic [7:0] time_bcd, disp_left, disp_right, high_score;
  int         n_chk = 0, n_fail = 0;

  game_sequencer #(.COUNTDOWN_SEC(3), .GAME_SEC(12), .NUM_PLAYERS(2), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_diff(btn_diff), .diff_in(diff_in), .score(score), .state_o(state_o), .clear_score(clear_score),
    .play_en(play_en), .difficulty(difficulty), .player_idx(player_idx), .time_bcd(time_bcd),
    .disp_left(disp_left), .disp_right(disp_right), .high_score(high_score), .new_high(new_high),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic t, input logic s, input logic p, input logic d);
    tick_1hz = t; btn_start = s; btn_pause = p; btn_diff = d;
    @(posedge clk);
    #1 tick_1hz = 0; btn_start = 0; btn_pause = 0; btn_diff = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_outs", {clear_score, play_en, new_high, game_over, time_bcd, disp_left, disp_right, high_score}, 0);
    rst_n = 1;
    ticks(2);
    chk("idle_tick", state_o, 0);
    diff_in = 3; step(0, 0, 0, 1);
    chk("diff_sat", difficulty, 2);
    chk("diff_disp", disp_right, 2);
    step(0, 1, 0, 0);
    chk("cd_state", state_o, 1);
    chk("cd_clear", clear_score, 1);
    chk("cd_time", time_bcd, 8'h03);
    chk("cd_disp", disp_left, 8'h03);
    step(0, 0, 0, 0);
    chk("clear_once", clear_score, 0);
    step(0, 0, 1, 0);
    chk("cd_pause_ign", state_o, 1);
    ticks(1); chk("cd_02", time_bcd, 8'h02);
    ticks(1); chk("cd_01", time_bcd, 8'h01);
    ticks(1);
    chk("pl_state", state_o, 2);
    chk("pl_time", time_bcd, 8'h12);
    chk("pl_en", play_en, 1);
    diff_in = 1; step(0, 0, 0, 1);
    chk("diff_hold", difficulty, 2);
    ticks(2); chk("pl_10", time_bcd, 8'h10);
    ticks(1); chk("pl_09", time_bcd, 8'h09);
    ticks(2); chk("pl_07", time_bcd, 8'h07);
    step(0, 0, 1, 0);
    chk("pa_state", state_o, 3);
    chk("pa_en", play_en, 0);
    ticks(5);
    chk("pa_freeze", time_bcd, 8'h07);
    step(0, 0, 1, 0);
    chk("resume", state_o, 2);
    ticks(1); chk("pl_06", time_bcd, 8'h06);
    score = 40;
    ticks(5); chk("pl_01", time_bcd, 8'h01);
    ticks(1);
    chk("te_state", state_o, 4);
    chk("te_time", time_bcd, 8'h00);
    chk("te_newhigh", new_high, 1);
    chk("te_high", high_score, 40);
    step(0, 0, 0, 0);
    chk("p1_state", state_o, 1);
    chk("p1_idx", player_idx, 1);
    chk("p1_clear", clear_score, 1);
    chk("p1_time", time_bcd, 8'h03);
    chk("p1_nh_off", new_high, 0);
    score = 0;
    ticks(3);
    score = 40;
    ticks(12);
    chk("te2_state", state_o, 4);
    chk("te2_nonew", new_high, 0);
    step(0, 0, 0, 0);
    chk("go_state", state_o, 5);
    chk("go_flag", game_over, 1);
    chk("go_left", disp_left, 8'h00);
    chk("go_right", disp_right, 40);
    chk("go_high", high_score, 40);
    ticks(1);
    chk("go_tick", state_o, 5);
    score = 0;
    step(0, 1, 0, 0);
    chk("rs_state", state_o, 1);
    chk("rs_idx", player_idx, 0);
    chk("rs_high", high_score, 40);
    ticks(5);
    chk("mid_pl", time_bcd, 8'h10);
    step(1, 1, 1, 0);
    chk("prio_state", state_o, 1);
    chk("prio_idx", player_idx, 0);
    chk("prio_time", time_bcd, 8'h03);
    ticks(4);
    chk("pre_abort", play_en, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_state", state_o, 0);
    chk("abort_en", play_en, 0);
    chk("abort_high", {new_high, high_score}, 0);
    #3 rst_n = 1;
    ticks(3);
    chk("abort_idle", state_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
